// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W            = 5;
    localparam int unsigned WAIT_CNT_W       = 8;
    localparam int unsigned STALL_CNT_W      = 16;
    localparam int unsigned WAIT_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    // Per-cycle pipeline register controls, MSB first as listed.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_hz_we;
        logic ifid_clear;
        logic idex_we;
        logic idex_clear;
        logic exmem_we;
        logic memwb_clear;
        logic ic_abort;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_DWAIT = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_RST   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic logic is_wait(input state_t s);
        return (s == I_WAIT) || (s == D_WAIT);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_lu.sv
// Load-use hazard detector: a load in execute feeds a source of the decode instruction.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_lu
);

    logic w_rd_nonzero;
    logic w_rd_match;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_rd_match   = (i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt);
    assign o_lu         = i_ex_mem_read && w_rd_nonzero && w_rd_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, I/D cache miss waits,
// flush handling with I-fill abort, stall statistics and wait-timeout flag.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ic_miss,
    input  logic                   ic_ready,
    input  logic                   dc_miss,
    input  logic                   dc_ready,
    input  logic                   id_jump,
    input  logic                   ex_flush,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   ifid_hz_we,
    output logic                   ifid_clear,
    output logic                   idex_we,
    output logic                   idex_clear,
    output logic                   exmem_we,
    output logic                   memwb_clear,
    output logic                   ic_abort,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   err
);

    state_t                 r_state;
    state_t                 w_state_next;
    ctrl_t                  w_ctrl;
    logic                   w_lu;
    logic                   w_flush;
    logic                   w_enter_wait;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [WAIT_CNT_W-1:0]  w_wait_inc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   r_err;

    load_use_detect u_lu (
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rd       (ex_rd),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .o_lu          (w_lu)
    );

    assign w_flush = ex_flush || id_jump;

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and controls; a D-miss freezes everything and wins over all else
    always_comb begin
        w_ctrl       = CTRL_RUN;
        w_state_next = r_state;
        if (rst) begin
            w_ctrl       = CTRL_RST;
            w_state_next = RUN;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (dc_miss) begin
                        w_ctrl       = CTRL_DWAIT;
                        w_state_next = D_WAIT;
                    end else if (w_flush) begin
                        w_ctrl.ifid_clear = 1'b1;
                        w_ctrl.idex_clear = ex_flush;
                    end else if (w_lu) begin
                        // Hold decode for one cycle; ic_miss is a level and is taken next cycle
                        w_ctrl.pc_we      = 1'b0;
                        w_ctrl.ifid_hz_we = 1'b0;
                        w_ctrl.idex_clear = 1'b1;
                    end else if (ic_miss) begin
                        w_ctrl.pc_we      = 1'b0;
                        w_ctrl.ifid_clear = 1'b1;
                        w_state_next      = I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (dc_miss) begin
                        w_ctrl       = CTRL_DWAIT;
                        w_state_next = D_WAIT;
                    end else if (w_flush) begin
                        w_ctrl.ifid_clear = 1'b1;
                        w_ctrl.idex_clear = ex_flush;
                        w_ctrl.ic_abort   = 1'b1;
                        w_state_next      = RUN;
                    end else begin
                        w_ctrl.pc_we      = 1'b0;
                        w_ctrl.ifid_clear = 1'b1;
                        if (ic_ready) begin
                            w_state_next = RUN;
                        end
                    end
                end
                D_WAIT: begin
                    w_ctrl = CTRL_DWAIT;
                    if (dc_ready) begin
                        w_state_next = RUN;
                    end
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    assign w_enter_wait = is_wait(w_state_next) && (w_state_next != r_state);
    assign w_wait_inc   = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WAIT_CNT_W'(1);

    // Wait-length counter, sticky timeout flag and stall statistics
    always_ff @(posedge clock) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_enter_wait) begin
                r_wait_cnt <= '0;
            end else if (is_wait(r_state)) begin
                r_wait_cnt <= w_wait_inc;
            end
            if (is_wait(r_state) && (w_wait_inc == WAIT_CNT_W'(WAIT_TIMEOUT))) begin
                r_err <= 1'b1;
            end
            if (!w_ctrl.pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign pc_we       = w_ctrl.pc_we;
    assign ifid_we     = w_ctrl.ifid_we;
    assign ifid_hz_we  = w_ctrl.ifid_hz_we;
    assign ifid_clear  = w_ctrl.ifid_clear;
    assign idex_we     = w_ctrl.idex_we;
    assign idex_clear  = w_ctrl.idex_clear;
    assign exmem_we    = w_ctrl.exmem_we;
    assign memwb_clear = w_ctrl.memwb_clear;
    assign ic_abort    = w_ctrl.ic_abort;
    assign stall_cnt   = r_stall_cnt;
    assign err         = r_err;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl (WAIT_TIMEOUT=4).
module tb_pipe_stall_ctrl;

    localparam logic [7:0] IN_NONE = 8'h00;
    localparam logic [7:0] IN_RST  = 8'h80;
    localparam logic [7:0] IN_LD   = 8'h40;
    localparam logic [7:0] IN_ICM  = 8'h20;
    localparam logic [7:0] IN_ICR  = 8'h10;
    localparam logic [7:0] IN_DCM  = 8'h08;
    localparam logic [7:0] IN_DCR  = 8'h04;
    localparam logic [7:0] IN_JMP  = 8'h02;
    localparam logic [7:0] IN_EXF  = 8'h01;

    // {pc_we, ifid_we, ifid_hz_we, ifid_clear, idex_we, idex_clear, exmem_we, memwb_clear, ic_abort}
    localparam logic [8:0] C_RUN = 9'b111010100;
    localparam logic [8:0] C_LU  = 9'b010011100;
    localparam logic [8:0] C_DW  = 9'b001000010;
    localparam logic [8:0] C_IW  = 9'b011110100;
    localparam logic [8:0] C_FLJ = 9'b111110100;
    localparam logic [8:0] C_FLX = 9'b111111100;
    localparam logic [8:0] C_ABX = 9'b111111101;
    localparam logic [8:0] C_ABJ = 9'b111110101;
    localparam logic [8:0] C_RST = 9'b011111110;

    logic        clock;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        ex_mem_read, ic_miss, ic_ready, dc_miss, dc_ready, id_jump, ex_flush;
    logic        pc_we, ifid_we, ifid_hz_we, ifid_clear, idex_we, idex_clear;
    logic        exmem_we, memwb_clear, ic_abort, err;
    logic [15:0] stall_cnt;

    logic [25:0] exp_q[$];
    string       name_q[$];
    logic [15:0] m_stall;
    int          n_vec;
    int          n_err;

    pipe_stall_ctrl #(.WAIT_TIMEOUT(4)) dut (
        .clock       (clock),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ic_miss     (ic_miss),
        .ic_ready    (ic_ready),
        .dc_miss     (dc_miss),
        .dc_ready    (dc_ready),
        .id_jump     (id_jump),
        .ex_flush    (ex_flush),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_hz_we  (ifid_hz_we),
        .ifid_clear  (ifid_clear),
        .idex_we     (idex_we),
        .idex_clear  (idex_clear),
        .exmem_we    (exmem_we),
        .memwb_clear (memwb_clear),
        .ic_abort    (ic_abort),
        .stall_cnt   (stall_cnt),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of inputs and queue its expected controls, stall count and err
    task automatic drive(input logic [7:0] vin, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [8:0] ec, input logic ee,
                         input string nm);
        @(posedge clock);
        #1;
        {rst, ex_mem_read, ic_miss, ic_ready, dc_miss, dc_ready, id_jump, ex_flush} = vin;
        ex_rd = rd;
        id_rs = rs;
        id_rt = rt;
        exp_q.push_back({ec, m_stall, ee});
        name_q.push_back(nm);
        if (vin[7]) m_stall = 16'd0;
        else if (!ec[8] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    endtask

    // Monitor: outputs are valid every cycle, compare mid-cycle
    always @(negedge clock) begin
        logic [25:0] got;
        logic [25:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {pc_we, ifid_we, ifid_hz_we, ifid_clear, idex_we, idex_clear,
                   exmem_we, memwb_clear, ic_abort, stall_cnt, err};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: ctrl/stall/err got %b/%0d/%b expected %b/%0d/%b",
                         nm, got[25:17], got[16:1], got[0], e[25:17], e[16:1], e[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        m_stall = 16'd0;
        {rst, ex_mem_read, ic_miss, ic_ready, dc_miss, dc_ready, id_jump, ex_flush} = IN_RST;
        ex_rd = 5'd0;
        id_rs = 5'd0;
        id_rt = 5'd0;
        repeat (2) @(posedge clock);

        drive(IN_RST,  0, 0, 0, C_RST, 1'b0, "reset");
        drive(IN_NONE, 0, 0, 0, C_RUN, 1'b0, "idle");

        // Load-use
        drive(IN_LD,  5, 5, 0, C_LU,  1'b0, "lu_rs");
        drive(IN_NONE, 5, 5, 0, C_RUN, 1'b0, "lu_done");
        drive(IN_LD,  5, 3, 5, C_LU,  1'b0, "lu_rt");
        drive(IN_LD,  0, 0, 0, C_RUN, 1'b0, "lu_rd0");
        drive(IN_LD,  5, 6, 7, C_RUN, 1'b0, "lu_nomatch");
        drive(IN_LD | IN_JMP, 5, 5, 0, C_FLJ, 1'b0, "lu_jump");
        drive(IN_EXF, 0, 0, 0, C_FLX, 1'b0, "exflush");

        // D-miss 10 cycles, ready on the last; err appears after 4 wait cycles
        drive(IN_RST, 0, 0, 0, C_RST, 1'b0, "rst_pre_dmiss");
        for (int i = 0; i < 10; i++)
            drive(IN_DCM | ((i == 9) ? IN_DCR : IN_NONE), 0, 0, 0, C_DW, (i >= 5), "dmiss");
        drive(IN_NONE, 0, 0, 0, C_RUN, 1'b1, "dmiss_exit");
        drive(IN_NONE, 0, 0, 0, C_RUN, 1'b1, "err_sticky");
        drive(IN_RST,  0, 0, 0, C_RST, 1'b1, "rst_err");
        drive(IN_NONE, 0, 0, 0, C_RUN, 1'b0, "post_rst");

        // Simultaneous D and I miss
        drive(IN_DCM | IN_ICM,          0, 0, 0, C_DW,  1'b0, "sim_dmiss");
        drive(IN_DCM | IN_ICM | IN_DCR, 0, 0, 0, C_DW,  1'b0, "sim_dready");
        drive(IN_ICM,                   0, 0, 0, C_IW,  1'b0, "sim_ientry");
        drive(IN_ICM,                   0, 0, 0, C_IW,  1'b0, "sim_iwait");
        drive(IN_ICM | IN_ICR,          0, 0, 0, C_IW,  1'b0, "sim_iready");
        drive(IN_NONE,                  0, 0, 0, C_RUN, 1'b0, "sim_run");

        // ex_flush in third I_WAIT cycle aborts the fill
        drive(IN_ICM,          0, 0, 0, C_IW,  1'b0, "ab_entry");
        drive(IN_ICM,          0, 0, 0, C_IW,  1'b0, "ab_w1");
        drive(IN_ICM,          0, 0, 0, C_IW,  1'b0, "ab_w2");
        drive(IN_ICM | IN_EXF, 0, 0, 0, C_ABX, 1'b0, "ab_flush");
        drive(IN_NONE,         0, 0, 0, C_RUN, 1'b0, "ab_run");

        // Jump outranks ic_ready in I_WAIT
        drive(IN_ICM,                   0, 0, 0, C_IW,  1'b0, "abj_entry");
        drive(IN_ICM | IN_ICR | IN_JMP, 0, 0, 0, C_ABJ, 1'b0, "abj_jump");
        drive(IN_NONE,                  0, 0, 0, C_RUN, 1'b0, "abj_run");

        // D-miss during I_WAIT, then I_WAIT re-entered through RUN
        drive(IN_ICM,          0, 0, 0, C_IW,  1'b0, "id_entry");
        drive(IN_ICM | IN_DCM, 0, 0, 0, C_DW,  1'b0, "id_dmiss");
        drive(IN_ICM | IN_DCR, 0, 0, 0, C_DW,  1'b0, "id_dready");
        drive(IN_ICM,          0, 0, 0, C_IW,  1'b0, "id_reenter");
        drive(IN_ICM | IN_ICR, 0, 0, 0, C_IW,  1'b0, "id_iready");
        drive(IN_NONE,         0, 0, 0, C_RUN, 1'b0, "id_run");

        // Reset in I_WAIT with a flush pending: no abort
        drive(IN_ICM,                   0, 0, 0, C_IW,  1'b0, "ri_entry");
        drive(IN_RST | IN_ICM | IN_EXF, 0, 0, 0, C_RST, 1'b0, "ri_rst");
        drive(IN_NONE,                  0, 0, 0, C_RUN, 1'b0, "ri_run");

        // Reset mid D_WAIT after err has set
        for (int i = 0; i < 6; i++)
            drive(IN_DCM, 0, 0, 0, C_DW, (i >= 5), "rm_wait");
        drive(IN_RST | IN_DCM, 0, 0, 0, C_RST, 1'b1, "rm_rst");
        drive(IN_NONE,         0, 0, 0, C_RUN, 1'b0, "rm_run");

        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
